// File: rtl/led_arb_pkg.sv
// Shared types and the round-robin helper for the LED bank arbiter.
package led_arb_pkg;

  localparam int unsigned LED_W   = 4;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    LINGER = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Search starts at last+1 and wraps at n, so the previous owner is considered last.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   last,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = 32'(last) + k;
      if (cand >= n) begin
        cand = cand - n;
      end
      if ((k <= n) && !res.valid && req[cand[IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_HZ/TICK_HZ clocks.
module led_tick_gen #(
  parameter int unsigned CLK_HZ  = 33333333,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 4-bit LED bank with a minimum hold time and an idle heartbeat.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CLK_HZ     = 33333333,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned HOLD_TICKS = 250,
  parameter int unsigned HB_TICKS   = 500
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [LED_W*NREQ-1:0]   pat,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [LED_W-1:0]        led
);

  localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned HB_W   = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;

  arb_state_e         r_state, w_state_d;
  logic [NREQ-1:0]    r_grant, w_grant_d;
  logic [LED_W-1:0]   r_led, w_led_d;
  logic               r_busy;
  logic [HOLD_W-1:0]  r_hold, w_hold_d, w_hold_dec;
  logic [IDX_W-1:0]   r_last, w_last_d;
  logic               r_hb, w_hb_d, w_hb_wrap;
  logic [HB_W-1:0]    r_hb_cnt;

  logic               w_tick;
  logic [MAX_REQ-1:0] w_req_ext;
  rr_pick_t           w_pick;
  logic [NREQ-1:0]    w_win_grant;
  logic [LED_W-1:0]   w_win_pat, w_owner_pat, w_hb_led;
  logic               w_owner_req;
  logic               w_rearb;

  led_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .tick   (w_tick)
  );

  assign w_hb_wrap = w_tick && (r_hb_cnt == HB_W'(HB_TICKS - 1));
  assign w_hb_d    = r_hb ^ w_hb_wrap;
  assign w_hb_led  = {{(LED_W-1){1'b0}}, w_hb_d};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hb     <= 1'b0;
      r_hb_cnt <= '0;
    end else begin
      r_hb <= w_hb_d;
      if (w_hb_wrap) begin
        r_hb_cnt <= '0;
      end else if (w_tick) begin
        r_hb_cnt <= r_hb_cnt + HB_W'(1);
      end
    end
  end

  // Decode the current owner and the round-robin winner into patterns and masks.
  always_comb begin
    w_req_ext            = '0;
    w_req_ext[NREQ-1:0]  = req;
    w_pick               = rr_pick(w_req_ext, r_last, NREQ);
    w_win_grant          = '0;
    w_win_pat            = '0;
    w_owner_pat          = '0;
    w_owner_req          = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_pick.idx == IDX_W'(i)) begin
        w_win_grant[i] = 1'b1;
        w_win_pat      = pat[LED_W*i +: LED_W];
      end
      if (r_last == IDX_W'(i)) begin
        w_owner_pat = pat[LED_W*i +: LED_W];
        w_owner_req = req[i];
      end
    end
  end

  assign w_hold_dec = (w_tick && (r_hold != '0)) ? r_hold - HOLD_W'(1) : r_hold;

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_led_d   = r_led;
    w_last_d  = r_last;
    w_hold_d  = w_hold_dec;
    w_rearb   = 1'b0;
    case (r_state)
      IDLE: begin
        w_led_d = w_hb_led;
        w_rearb = 1'b1;
      end
      OWN: begin
        w_led_d = w_owner_pat;
        // Expiry wins over an owner drop on the same cycle.
        if (r_hold == '0) begin
          w_rearb = 1'b1;
        end else if (!w_owner_req) begin
          w_state_d = LINGER;
          w_led_d   = r_led;
        end
      end
      LINGER: begin
        if (r_hold == '0) begin
          w_rearb = 1'b1;
        end else if (w_owner_req) begin
          w_state_d = OWN;
          w_led_d   = w_owner_pat;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_grant_d = '0;
      end
    endcase

    if (w_rearb) begin
      if (w_pick.valid) begin
        w_state_d = OWN;
        w_grant_d = w_win_grant;
        w_led_d   = w_win_pat;
        w_hold_d  = HOLD_W'(HOLD_TICKS);
        w_last_d  = w_pick.idx;
      end else begin
        w_state_d = IDLE;
        w_grant_d = '0;
        w_led_d   = w_hb_led;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_hold  <= '0;
      r_last  <= IDX_W'(NREQ - 1);
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_led   <= w_led_d;
      r_busy  <= (w_state_d != IDLE);
      r_hold  <= w_hold_d;
      r_last  <= w_last_d;
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign led   = r_led;

endmodule
